// File: rtl/upc_checkout_tracker_if.sv
// rtl/upc_checkout_tracker_if.sv - item handshake and per-item result bundle for the checkout tracker
//
// Purpose: groups the item handshake and the per-item classification result.
// Ports (signals):
//    item_valid     master->slave  item presented
//    item_code      master->slave  product code, CODE_W bits
//    item_mark      master->slave  item carries the security mark
//    item_ready     slave->master  tracker can accept an item this cycle
//    res_valid      slave->master  1-cycle pulse, res_* describe the last accepted item
//    res_discount   slave->master  item is discounted
//    res_expensive  slave->master  item is expensive and unmarked
//    res_stolen     slave->master  item is classified as stolen
// master = item source (front end / bench), slave = upc_checkout_tracker.

interface upc_checkout_tracker_if #(
   parameter int CODE_W = 3
);
   logic              item_valid;
   logic [CODE_W-1:0] item_code;
   logic              item_mark;
   logic              item_ready;
   logic              res_valid;
   logic              res_discount;
   logic              res_expensive;
   logic              res_stolen;

   modport master (
      output item_valid,
      output item_code,
      output item_mark,
      input  item_ready,
      input  res_valid,
      input  res_discount,
      input  res_expensive,
      input  res_stolen
   );

   modport slave (
      input  item_valid,
      input  item_code,
      input  item_mark,
      output item_ready,
      output res_valid,
      output res_discount,
      output res_expensive,
      output res_stolen
   );
endinterface

// File: rtl/upc_checkout_tracker.sv
// rtl/upc_checkout_tracker.sv - checkout item classifier with saturating session counters and theft alarm
//
// Purpose: classifies each accepted item as discount / expensive / stolen via
// parameter mask tables, keeps saturating session counters and latches a theft
// alarm until it is explicitly cleared.
// Ports:
//    clk            in   1      single clock, all state changes on posedge
//    reset          in   1      synchronous, active-high
//    item_if        slave       item handshake and registered per-item result
//    alarm_clear    in   1      acknowledge the theft alarm (only acted on in ALARM)
//    session_clear  in   1      end session: zero counters, return to IDLE
//    alarm          out  1      latched theft alarm, high exactly in ALARM
//    state          out  2      00 IDLE, 01 ACTIVE, 10 ALARM
//    total_cnt      out  CNT_W  items accepted this session
//    discount_cnt   out  CNT_W  accepted discounted items
//    stolen_cnt     out  CNT_W  accepted stolen items

module upc_checkout_tracker #(
   parameter int                     CODE_W           = 3,
   parameter int                     CNT_W            = 8,
   parameter logic [2**CODE_W-1:0]   DISCOUNT_MASK    = 8'b1110_1100,
   parameter logic [2**CODE_W-1:0]   EXPENSIVE_MASK   = 8'b0011_0001,
   parameter logic [2**CODE_W-1:0]   STOLEN_ANY_MASK  = 8'b0001_0000,
   parameter logic [2**CODE_W-1:0]   STOLEN_UNMK_MASK = 8'b0001_0001
) (
   input  logic                 clk,
   input  logic                 reset,
   upc_checkout_tracker_if.slave item_if,
   input  logic                 alarm_clear,
   input  logic                 session_clear,
   output logic                 alarm,
   output logic [1:0]           state,
   output logic [CNT_W-1:0]     total_cnt,
   output logic [CNT_W-1:0]     discount_cnt,
   output logic [CNT_W-1:0]     stolen_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACTIVE = 2'b01,
      ST_ALARM  = 2'b10
   } state_t;

   state_t state_q;
   state_t state_d;

   logic cls_discount;
   logic cls_expensive;
   logic cls_stolen;
   logic accept;

   logic             res_valid_q;
   logic             res_discount_q;
   logic             res_expensive_q;
   logic             res_stolen_q;
   logic [CNT_W-1:0] total_q;
   logic [CNT_W-1:0] discount_q;
   logic [CNT_W-1:0] stolen_q;

   // Counters stop at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}})
         return v;
      else
         return v + CNT_W'(1);
   endfunction

   // Mask lookups on the presented item; only registered on acceptance.
   always_comb begin
      cls_discount  = DISCOUNT_MASK[item_if.item_code];
      cls_expensive = EXPENSIVE_MASK[item_if.item_code] && !item_if.item_mark;
      cls_stolen    = STOLEN_ANY_MASK[item_if.item_code]
                      || (STOLEN_UNMK_MASK[item_if.item_code] && !item_if.item_mark);
   end

   // Ready depends only on state so the front end never sees a valid->ready loop.
   assign item_if.item_ready = (state_q != ST_ALARM);

   // session_clear outranks acceptance: a coinciding item is dropped entirely.
   assign accept = item_if.item_valid && item_if.item_ready && !session_clear;

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (session_clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept)
                  state_d = cls_stolen ? ST_ALARM : ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (accept && cls_stolen)
                  state_d = ST_ALARM;
            end
            ST_ALARM: begin
               if (alarm_clear)
                  state_d = ST_ACTIVE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Result registers and session counters. res_* hold until the next
   // acceptance; res_valid is a single-cycle pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         res_valid_q     <= 1'b0;
         res_discount_q  <= 1'b0;
         res_expensive_q <= 1'b0;
         res_stolen_q    <= 1'b0;
         total_q         <= '0;
         discount_q      <= '0;
         stolen_q        <= '0;
      end else if (session_clear) begin
         res_valid_q <= 1'b0;
         total_q     <= '0;
         discount_q  <= '0;
         stolen_q    <= '0;
      end else begin
         res_valid_q <= accept;
         if (accept) begin
            res_discount_q  <= cls_discount;
            res_expensive_q <= cls_expensive;
            res_stolen_q    <= cls_stolen;
            total_q         <= sat_inc(total_q);
            if (cls_discount)
               discount_q <= sat_inc(discount_q);
            if (cls_stolen)
               stolen_q <= sat_inc(stolen_q);
         end
      end
   end

   assign item_if.res_valid     = res_valid_q;
   assign item_if.res_discount  = res_discount_q;
   assign item_if.res_expensive = res_expensive_q;
   assign item_if.res_stolen    = res_stolen_q;

   // The stolen item moves state to ALARM on the same edge that raises its
   // res_valid, so alarm and the result pulse appear together.
   assign alarm        = (state_q == ST_ALARM);
   assign state        = state_q;
   assign total_cnt    = total_q;
   assign discount_cnt = discount_q;
   assign stolen_cnt   = stolen_q;

endmodule

// File: tb/tb_upc_checkout_tracker.sv
// tb/tb_upc_checkout_tracker.sv - directed-vector bench for upc_checkout_tracker

module tb_upc_checkout_tracker;

   logic clk = 1'b0;
   logic reset;
   logic alarm_clear;
   logic session_clear;

   logic       alarm_a;
   logic [1:0] state_a;
   logic [7:0] total_a, disc_a, stol_a;

   logic       alarm_b;
   logic [1:0] state_b;
   logic [1:0] total_b, disc_b, stol_b;

   int n_vec = 0;
   int n_err = 0;
   int pulses_a = 0;

   upc_checkout_tracker_if #(.CODE_W(3)) if_a ();
   upc_checkout_tracker_if #(.CODE_W(3)) if_b ();

   upc_checkout_tracker #(.CODE_W(3), .CNT_W(8)) u_dut_a (
      .clk           (clk),
      .reset         (reset),
      .item_if       (if_a),
      .alarm_clear   (alarm_clear),
      .session_clear (session_clear),
      .alarm         (alarm_a),
      .state         (state_a),
      .total_cnt     (total_a),
      .discount_cnt  (disc_a),
      .stolen_cnt    (stol_a)
   );

   upc_checkout_tracker #(.CODE_W(3), .CNT_W(2)) u_dut_b (
      .clk           (clk),
      .reset         (reset),
      .item_if       (if_b),
      .alarm_clear   (1'b0),
      .session_clear (1'b0),
      .alarm         (alarm_b),
      .state         (state_b),
      .total_cnt     (total_b),
      .discount_cnt  (disc_b),
      .stolen_cnt    (stol_b)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (if_a.res_valid) pulses_a++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one item on DUT A for exactly one posedge, return at the following negedge.
   task automatic send_a(input logic [2:0] code, input logic mark);
      if_a.item_valid = 1'b1;
      if_a.item_code  = code;
      if_a.item_mark  = mark;
      @(posedge clk);
      @(negedge clk);
      if_a.item_valid = 1'b0;
   endtask

   task automatic check_res_a(input string tag, input logic d, input logic e, input logic s);
      check_eq({tag, ".res_valid"},     if_a.res_valid,     1'b1);
      check_eq({tag, ".res_discount"},  if_a.res_discount,  d);
      check_eq({tag, ".res_expensive"}, if_a.res_expensive, e);
      check_eq({tag, ".res_stolen"},    if_a.res_stolen,    s);
   endtask

   // Expected classification of codes 0..7 with mark=1 (discount codes 2,3,5,6,7; stolen 4).
   logic [7:0] exp_disc_m1 = 8'b1110_1100;
   logic [7:0] exp_stol_m1 = 8'b0001_0000;

   initial begin
      reset = 1'b1; alarm_clear = 1'b0; session_clear = 1'b0;
      if_a.item_valid = 1'b0; if_a.item_code = '0; if_a.item_mark = 1'b0;
      if_b.item_valid = 1'b0; if_b.item_code = '0; if_b.item_mark = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset state
      check_eq("rst.state",     state_a,         2'b00);
      check_eq("rst.ready",     if_a.item_ready, 1'b1);
      check_eq("rst.res_valid", if_a.res_valid,  1'b0);
      check_eq("rst.alarm",     alarm_a,         1'b0);
      check_eq("rst.total",     total_a,         8'd0);
      check_eq("rst.res_disc",  if_a.res_discount, 1'b0);

      // 1: codes 0..4 marked, back to back; code 4 trips the alarm
      for (int c = 0; c < 5; c++) begin
         send_a(3'(c), 1'b1);
         check_res_a($sformatf("t1.code%0d", c), exp_disc_m1[c], 1'b0, exp_stol_m1[c]);
         check_eq($sformatf("t1.code%0d.state", c), state_a, (c == 4) ? 2'b10 : 2'b01);
      end
      check_eq("t1.alarm",    alarm_a, 1'b1);
      check_eq("t1.stol_cnt", stol_a,  8'd1);
      check_eq("t1.disc_cnt", disc_a,  8'd2);
      check_eq("t1.total",    total_a, 8'd5);

      // 2: hold code 5 in ALARM, nothing accepted
      if_a.item_valid = 1'b1; if_a.item_code = 3'd5; if_a.item_mark = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq($sformatf("t2.hold%0d.ready", i), if_a.item_ready, 1'b0);
         check_eq($sformatf("t2.hold%0d.rv", i),    if_a.res_valid,  1'b0);
         check_eq($sformatf("t2.hold%0d.total", i), total_a,         8'd5);
      end
      alarm_clear = 1'b1;
      @(negedge clk);
      alarm_clear = 1'b0;
      check_eq("t2.clr.state", state_a,        2'b01);
      check_eq("t2.clr.alarm", alarm_a,        1'b0);
      check_eq("t2.clr.rv",    if_a.res_valid, 1'b0);
      check_eq("t2.clr.total", total_a,        8'd5);
      @(negedge clk);
      if_a.item_valid = 1'b0;
      check_res_a("t2.code5", 1'b1, 1'b0, 1'b0);
      check_eq("t2.code5.total", total_a, 8'd6);
      for (int c = 6; c < 8; c++) begin
         send_a(3'(c), 1'b1);
         check_res_a($sformatf("t1.code%0d", c), exp_disc_m1[c], 1'b0, exp_stol_m1[c]);
      end
      @(negedge clk);
      check_eq("t1.idle_rv",  if_a.res_valid, 1'b0);
      check_eq("t1.res_hold", if_a.res_discount, 1'b1);
      check_eq("t1.pulses",   pulses_a, 8);
      check_eq("t1.end.total", total_a, 8'd8);
      check_eq("t1.end.disc",  disc_a,  8'd5);
      check_eq("t1.end.stol",  stol_a,  8'd1);

      // alarm_clear is ignored outside ALARM
      alarm_clear = 1'b1;
      @(negedge clk);
      alarm_clear = 1'b0;
      check_eq("aclr_active.state", state_a, 2'b01);

      // 3: code 0 unmarked is expensive and stolen; marked it is neither
      send_a(3'd0, 1'b0);
      check_res_a("t3.c0m0", 1'b0, 1'b1, 1'b1);
      check_eq("t3.c0m0.alarm", alarm_a, 1'b1);
      check_eq("t3.c0m0.stol",  stol_a,  8'd2);
      alarm_clear = 1'b1;
      @(negedge clk);
      alarm_clear = 1'b0;
      send_a(3'd0, 1'b1);
      check_res_a("t3.c0m1", 1'b0, 1'b0, 1'b0);
      check_eq("t3.c0m1.state", state_a, 2'b01);
      check_eq("t3.total",      total_a, 8'd10);

      // 5: session_clear wins over a coinciding item
      if_a.item_valid = 1'b1; if_a.item_code = 3'd2; if_a.item_mark = 1'b1;
      session_clear = 1'b1;
      @(negedge clk);
      session_clear = 1'b0;
      if_a.item_valid = 1'b0;
      check_eq("t5.rv",    if_a.res_valid, 1'b0);
      check_eq("t5.state", state_a,        2'b00);
      check_eq("t5.total", total_a,        8'd0);
      check_eq("t5.disc",  disc_a,         8'd0);
      check_eq("t5.stol",  stol_a,         8'd0);

      // 6: reset while in ALARM with nonzero counters
      send_a(3'd3, 1'b1);
      send_a(3'd4, 1'b1);
      check_eq("t6.pre.state", state_a, 2'b10);
      check_eq("t6.pre.total", total_a, 8'd2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("t6.state", state_a,             2'b00);
      check_eq("t6.ready", if_a.item_ready,     1'b1);
      check_eq("t6.alarm", alarm_a,             1'b0);
      check_eq("t6.rv",    if_a.res_valid,      1'b0);
      check_eq("t6.rd",    if_a.res_discount,   1'b0);
      check_eq("t6.rs",    if_a.res_stolen,     1'b0);
      check_eq("t6.total", total_a,             8'd0);
      check_eq("t6.disc",  disc_a,              8'd0);
      check_eq("t6.stol",  stol_a,              8'd0);

      // 4: CNT_W=2 counters saturate at 3
      for (int i = 0; i < 6; i++) begin
         if_b.item_valid = 1'b1; if_b.item_code = 3'd2; if_b.item_mark = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if_b.item_valid = 1'b0;
         check_eq($sformatf("t4.i%0d.rv", i),    if_b.res_valid, 1'b1);
         check_eq($sformatf("t4.i%0d.total", i), total_b, (i < 3) ? 32'(i + 1) : 32'd3);
         check_eq($sformatf("t4.i%0d.disc", i),  disc_b,  (i < 3) ? 32'(i + 1) : 32'd3);
      end
      check_eq("t4.stol", stol_b, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
